// File: rtl/serial_byte_framer_if.sv
// serial_byte_framer_if: serial line in, deframed byte bus and status out
interface serial_byte_framer_if;
    logic       in;
    logic [7:0] byte_out;
    logic       done;
    logic       frame_err;
    logic       busy;
    logic [7:0] byte_cnt;
    modport master (output in, input byte_out, done, frame_err, busy, byte_cnt);
    modport slave (input in, output byte_out, done, frame_err, busy, byte_cnt);
endinterface

// File: rtl/serial_byte_framer.sv
// serial_byte_framer: start/8 data/stop deframer, one bit per clk, with framing error flag and good-byte count
module serial_byte_framer #(
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    serial_byte_framer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, STOP, ERR} state_t;
    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       done_q, done_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_q, busy_d;
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_out_d  = byte_out_q;
        byte_cnt_d  = byte_cnt_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in == ~IDLE_LEVEL) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                shreg_d   = LSB_FIRST ? {bus.in, shreg_q[7:1]} : {shreg_q[6:0], bus.in};
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = (bit_cnt_q == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                if (bus.in == IDLE_LEVEL) begin
                    byte_out_d = shreg_q;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ERR;
                end
            end
            ERR: state_d = (bus.in == IDLE_LEVEL) ? IDLE : ERR;
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_out_q  <= 8'h00;
            byte_cnt_q  <= 8'h00;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_out_q  <= byte_out_d;
            byte_cnt_q  <= byte_cnt_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end
    assign bus.byte_out  = byte_out_q;
    assign bus.byte_cnt  = byte_cnt_q;
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_byte_framer.sv
// tb_serial_byte_framer: frame-level model builds a line script with per-cycle expectations for LSB- and MSB-first framers
module tb_serial_byte_framer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    serial_byte_framer_if bus_a ();
    serial_byte_framer_if bus_b ();
    serial_byte_framer #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    serial_byte_framer #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    always #5 clk = ~clk;
    logic       q_rst[$], q_in[$], q_busy[$], q_done[$], q_err[$];
    logic [7:0] q_byte[$], q_cnt[$];
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask
    function automatic logic [7:0] rev(input logic [7:0] v);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = v[7-j];
        return r;
    endfunction
    task automatic push(input logic r, input logic b, input logic bz, input logic dn, input logic er);
        q_rst.push_back(r);
        q_in.push_back(b);
        q_busy.push_back(bz);
        q_done.push_back(dn);
        q_err.push_back(er);
        q_byte.push_back(m_byte);
        q_cnt.push_back(m_cnt);
    endtask
    task automatic idle(input int n);
        repeat (n) push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_reset(input int n);
        m_byte = 8'h00;
        m_cnt  = 8'h00;
        repeat (n) push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic frame(input logic [7:0] d, input logic good, input int hold);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) push(1'b0, d[j], 1'b1, 1'b0, 1'b0);
        if (good) begin
            m_byte = d;
            m_cnt  = m_cnt + 8'd1;
            push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            repeat (hold) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask
    task automatic partial(input logic [7:0] d, input int nbits);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < nbits; j++) push(1'b0, d[j], 1'b1, 1'b0, 1'b0);
    endtask
    initial begin
        bus_a.in = 1'b1;
        bus_b.in = 1'b1;
        do_reset(2);
        idle(20);
        frame(8'h5A, 1'b1, 0);
        frame(8'hFF, 1'b1, 0);
        frame(8'h00, 1'b1, 0);
        frame(8'hA5, 1'b0, 5);
        frame(8'h3C, 1'b1, 0);
        idle(3);
        partial(8'hC3, 4);
        do_reset(2);
        frame(8'h81, 1'b1, 0);
        for (int k = 0; k < 40; k++) begin
            idle(int'($urandom_range(0, 3)));
            frame(8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(0, 6)));
        end
        idle(2);
        do_reset(1);
        for (int k = 0; k < 256; k++) frame(8'($urandom), 1'b1, 0);
        idle(3);
        for (int i = 0; i < q_in.size(); i++) begin
            reset    = q_rst[i];
            bus_a.in = q_in[i];
            bus_b.in = q_in[i];
            @(posedge clk);
            #1;
            check("done", {7'd0, bus_a.done}, {7'd0, q_done[i]});
            check("frame_err", {7'd0, bus_a.frame_err}, {7'd0, q_err[i]});
            check("busy", {7'd0, bus_a.busy}, {7'd0, q_busy[i]});
            check("byte_out", bus_a.byte_out, q_byte[i]);
            check("byte_cnt", bus_a.byte_cnt, q_cnt[i]);
            check("msb_byte_out", bus_b.byte_out, rev(q_byte[i]));
            check("msb_done", {7'd0, bus_b.done}, {7'd0, q_done[i]});
        end
        check("final_cnt_wrapped", bus_a.byte_cnt, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
